// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet RX constants and state type
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam int          FCS_DELAY     = 5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - combinational reflected CRC-32 update by one byte
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_frame_aligner.sv
// rtl/eth_rx_frame_aligner.sv - preamble/SFD strip, FCS strip via 5-byte delay line, CRC/length check
module eth_rx_frame_aligner
    import eth_pkg::*;
#(
    parameter int RGMII_W      = 8,
    parameter int MIN_PREAMBLE = 3,
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1518,
    parameter int LEN_W        = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RGMII_W-1:0] rx_data,
    input  logic               rx_valid,
    output logic [RGMII_W-1:0] m_data,
    output logic               m_valid,
    output logic               m_sof,
    output logic               m_eof,
    output logic               m_err,
    output logic [LEN_W-1:0]   m_len,
    output logic               drop
);

    rx_state_t          state_q, state_d;
    logic               prev_valid_q, prev_valid_d;
    logic [2:0]         pcnt_q, pcnt_d;
    logic [31:0]        crc_q, crc_d;
    logic [31:0]        crc_next;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [RGMII_W-1:0] buf_q [FCS_DELAY];
    logic [RGMII_W-1:0] buf_d [FCS_DELAY];
    logic [2:0]         cnt_q, cnt_d;
    logic               first_q, first_d;
    logic [RGMII_W-1:0] m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               m_sof_q, m_sof_d;
    logic               m_eof_q, m_eof_d;
    logic               m_err_q, m_err_d;
    logic [LEN_W-1:0]   m_len_q, m_len_d;
    logic               drop_q, drop_d;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data_in (rx_data),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        prev_valid_d = rx_valid;
        pcnt_d       = pcnt_q;
        crc_d        = crc_q;
        len_d        = len_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        m_data_d     = '0;
        m_valid_d    = 1'b0;
        m_sof_d      = 1'b0;
        m_eof_d      = 1'b0;
        m_err_d      = 1'b0;
        m_len_d      = '0;
        drop_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // A burst already underway (e.g. at reset release) is skipped silently.
                if (rx_valid) begin
                    if (prev_valid_q) begin
                        state_d = DROP;
                    end else if (rx_data == PREAMBLE_BYTE) begin
                        state_d = PREAMBLE;
                        pcnt_d  = 3'd1;
                    end else begin
                        state_d = DROP;
                        drop_d  = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end else if (rx_data == PREAMBLE_BYTE) begin
                    pcnt_d = (pcnt_q == 3'd7) ? pcnt_q : pcnt_q + 3'd1;
                end else if (rx_data == SFD_BYTE && 32'(pcnt_q) >= MIN_PREAMBLE) begin
                    state_d = DATA;
                    crc_d   = CRC32_INIT;
                    len_d   = '0;
                    cnt_d   = 3'd0;
                    first_d = 1'b1;
                end else begin
                    state_d = DROP;
                    drop_d  = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    crc_d = crc_next;
                    len_d = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
                    if (cnt_q == 3'(FCS_DELAY)) begin
                        m_valid_d = 1'b1;
                        m_data_d  = buf_q[0];
                        m_sof_d   = first_q;
                        first_d   = 1'b0;
                        for (int i = 0; i < FCS_DELAY - 1; i++) begin
                            buf_d[i] = buf_q[i+1];
                        end
                        buf_d[FCS_DELAY-1] = rx_data;
                    end else begin
                        buf_d[cnt_q] = rx_data;
                        cnt_d        = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = IDLE;
                    // The four youngest bytes are the FCS and are never emitted.
                    if (cnt_q == 3'(FCS_DELAY)) begin
                        m_valid_d = 1'b1;
                        m_data_d  = buf_q[0];
                        m_sof_d   = first_q;
                        m_eof_d   = 1'b1;
                        m_len_d   = len_q;
                        m_err_d   = (crc_q != CRC32_RESIDUE)
                                  || (len_q < LEN_W'(MIN_FRAME))
                                  || (len_q > LEN_W'(MAX_FRAME));
                    end else begin
                        drop_d = 1'b1;
                    end
                    first_d = 1'b0;
                end
            end
            DROP: begin
                if (!rx_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            prev_valid_q <= 1'b1;
            pcnt_q       <= 3'd0;
            crc_q        <= CRC32_INIT;
            len_q        <= '0;
            cnt_q        <= 3'd0;
            first_q      <= 1'b0;
            for (int i = 0; i < FCS_DELAY; i++) begin
                buf_q[i] <= '0;
            end
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            m_err_q      <= 1'b0;
            m_len_q      <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= prev_valid_d;
            pcnt_q       <= pcnt_d;
            crc_q        <= crc_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            buf_q        <= buf_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_sof_q      <= m_sof_d;
            m_eof_q      <= m_eof_d;
            m_err_q      <= m_err_d;
            m_len_q      <= m_len_d;
            drop_q       <= drop_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_sof   = m_sof_q;
    assign m_eof   = m_eof_q;
    assign m_err   = m_err_q;
    assign m_len   = m_len_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_eth_rx_frame_aligner.sv
// tb/tb_eth_rx_frame_aligner.sv - randomized frame stream against a frame-level reference model
module tb_eth_rx_frame_aligner;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_sof;
    logic        m_eof;
    logic        m_err;
    logic [11:0] m_len;
    logic        drop;

    eth_rx_frame_aligner dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_sof    (m_sof),
        .m_eof    (m_eof),
        .m_err    (m_err),
        .m_len    (m_len),
        .drop     (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [11:0] len;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] frm[$];
    logic [7:0] pay[$];
    int         frm_p0;
    int         exp_drop_total = 0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pay0_cyc = 0;
    int         n_beats = 0, n_sof = 0, n_eof = 0, n_drop = 0, n_err = 0;
    int         last_len = 0, last_err = 0, sof_cyc = 0;
    int         b0, s0, e0, d0, r0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Straightforward bitwise CRC-32 with final inversion, i.e. the FCS value.
    function automatic logic [31:0] crc32_range(input logic [7:0] q[$], input int s, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = s; i < s + n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    initial forever begin
        @(negedge clk);
        if (drop === 1'b1) n_drop++;
        if (m_valid === 1'b1) begin
            n_beats++;
            if (m_sof) begin n_sof++; sof_cyc = cyc; end
            if (m_eof) begin n_eof++; last_len = int'(m_len); last_err = int'(m_err); n_err += int'(m_err); end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h expected no beat", m_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(e.d));
                check("beat_sof", 32'(m_sof), 32'(e.sof));
                check("beat_eof", 32'(m_eof), 32'(e.eof));
                if (e.eof) begin
                    check("eof_err", 32'(m_err), 32'(e.err));
                    check("eof_len", 32'(m_len), 32'(e.len));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        rst      = r;
    endtask

    task automatic build_frame(input int npre, input int npay, input int flip, input logic [7:0] sfd);
        logic [31:0] fcs;
        frm.delete();
        pay.delete();
        for (int i = 0; i < npre; i++) frm.push_back(8'h55);
        frm.push_back(sfd);
        for (int i = 0; i < npay; i++) pay.push_back(8'($urandom));
        fcs = crc32_range(pay, 0, npay);
        if (flip >= 0) pay[flip] = pay[flip] ^ 8'h01;
        for (int i = 0; i < npay; i++) frm.push_back(pay[i]);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        frm_p0 = npre + 1;
    endtask

    // Frame-level rules: preamble run, SFD, then everything but the last 4 bytes is payload.
    task automatic run_model();
        int          i = 0;
        int          n;
        logic [7:0]  post[$];
        logic [31:0] fcs_rx;
        logic        err;
        logic [11:0] len;
        beat_t       b;
        if (frm[0] != 8'h55) begin exp_drop_total++; return; end
        while (i < frm.size() && frm[i] == 8'h55) i++;
        if (i == frm.size() || frm[i] != 8'hD5 || i < 3) begin exp_drop_total++; return; end
        for (int j = i + 1; j < frm.size(); j++) post.push_back(frm[j]);
        n = post.size();
        if (n <= 4) begin exp_drop_total++; return; end
        fcs_rx = {post[n-1], post[n-2], post[n-3], post[n-4]};
        err = (crc32_range(post, 0, n - 4) != fcs_rx) || (n < 64) || (n > 1518);
        len = (n > 4095) ? 12'd4095 : 12'(n);
        for (int k = 0; k <= n - 5; k++) begin
            b.d   = post[k];
            b.sof = (k == 0);
            b.eof = (k == n - 5);
            b.err = b.eof ? err : 1'b0;
            b.len = b.eof ? len : 12'd0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_frm(input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, frm[i], 1'b1);
            if (i == frm_p0) pay0_cyc = cyc;
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic snap();
        b0 = n_beats; s0 = n_sof; e0 = n_eof; d0 = n_drop; r0 = n_err;
    endtask

    task automatic frame_test(input string tag, input int npre, input int npay, input int flip,
                              input int beats, input int len, input int err);
        build_frame(npre, npay, flip, 8'hD5);
        run_model();
        snap();
        send_frm(3);
        check({tag, "_beats"}, 32'(n_beats - b0), 32'(beats));
        check({tag, "_eof"}, 32'(n_eof - e0), 32'(beats > 0 ? 1 : 0));
        check({tag, "_drop"}, 32'(n_drop - d0), 32'(beats > 0 ? 0 : 1));
        if (beats > 0) begin
            check({tag, "_len"}, 32'(last_len), 32'(len));
            check({tag, "_err"}, 32'(last_err), 32'(err));
        end
        check({tag, "_model_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_sof", 32'(m_sof), 0);
        check("rst_m_eof", 32'(m_eof), 0);
        check("rst_m_err", 32'(m_err), 0);
        check("rst_m_len", 32'(m_len), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_drop", 32'(drop), 0);
        repeat (3) drive(1'b0, 8'h00, 1'b1);

        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        check("model_crc_check_value", crc32_range(pay, 0, 9), 32'hCBF43926);

        frame_test("good64", 7, 60, -1, 60, 64, 0);
        check("good64_sof", 32'(n_sof - s0), 1);
        check("good64_latency", 32'(sof_cyc - pay0_cyc), 6);
        frame_test("badcrc", 7, 60, 10, 60, 64, 1);
        frame_test("runt", 7, 59, -1, 59, 63, 1);
        frame_test("giant", 7, 1515, -1, 1515, 1519, 1);
        frame_test("short_pre", 2, 60, -1, 0, 0, 0);
        frame_test("single", 7, 1, -1, 1, 5, 1);
        check("single_sof", 32'(n_sof - s0), 1);

        build_frame(7, 0, -1, 8'hD5);
        void'(frm.pop_back());
        run_model();
        snap();
        send_frm(3);
        check("post3_beats", 32'(n_beats - b0), 0);
        check("post3_drop", 32'(n_drop - d0), 1);

        // Reset asserted for two cycles after 20 payload bytes, released mid-burst.
        build_frame(7, 60, -1, 8'hD5);
        for (int k = 0; k < 15; k++) begin
            beat_t b;
            b.d = pay[k]; b.sof = (k == 0); b.eof = 1'b0; b.err = 1'b0; b.len = 12'd0;
            exp_q.push_back(b);
        end
        snap();
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], (i == 28 || i == 29) ? 1'b0 : 1'b1);
        repeat (3) drive(1'b0, 8'h00, 1'b1);
        check("rstmid_beats", 32'(n_beats - b0), 15);
        check("rstmid_eof", 32'(n_eof - e0), 0);
        check("rstmid_drop", 32'(n_drop - d0), 0);
        check("rstmid_drained", 32'(exp_q.size()), 0);
        frame_test("after_rst", 7, 60, -1, 60, 64, 0);

        snap();
        build_frame(7, 60, -1, 8'hD5); run_model(); send_frm(1);
        build_frame(7, 60, -1, 8'hD5); run_model(); send_frm(3);
        check("b2b_beats", 32'(n_beats - b0), 120);
        check("b2b_sof", 32'(n_sof - s0), 2);
        check("b2b_eof", 32'(n_eof - e0), 2);
        check("b2b_errs", 32'(n_err - r0), 0);

        for (int it = 0; it < 40; it++) begin
            int          npre = $urandom_range(0, 8);
            int          npay = $urandom_range(0, 90);
            int          flip = -1;
            logic [7:0]  sfd = ($urandom_range(0, 7) == 0) ? 8'hD4 : 8'hD5;
            if (npay > 0 && $urandom_range(0, 3) == 0) flip = $urandom_range(0, npay - 1);
            build_frame(npre, npay, flip, sfd);
            run_model();
            send_frm($urandom_range(1, 3));
        end
        repeat (4) drive(1'b0, 8'h00, 1'b1);
        check("final_drained", 32'(exp_q.size()), 0);
        check("final_drop_total", 32'(n_drop), 32'(exp_drop_total));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_aligner.md
Name: eth_rx_frame_aligner

Overview:
- Receive-side front end that directly feeds packet_parser_top's RGMII RX interface path.
- Takes the raw 8-bit byte stream (rx_data/rx_valid, RX_DV semantics) and validates and strips preamble/SFD.
- Strips the 4-byte FCS using a 5-byte delay line, checks CRC-32, and emits framed payload bytes with sof/eof/err and frame length.
- No backpressure; RGMII cannot stall.

Parameters:
- RGMII_W, 8: byte width; only 8 supported.
- MIN_PREAMBLE, 3: minimum count of 0x55 bytes before SFD for acceptance.
- MIN_FRAME, 64: minimum post-SFD length including FCS; shorter frames are flagged err.
- MAX_FRAME, 1518: maximum post-SFD length including FCS; longer frames are flagged err.
- LEN_W, 12: width of length counter and m_len.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- rx_data  in  RGMII_W  received byte.
- rx_valid  in  1  byte-valid / data-valid strobe.
- m_data  out  RGMII_W  payload byte (post-SFD, FCS removed).
- m_valid  out  1  m_data valid this cycle.
- m_sof  out  1  first payload byte of frame; qualified by m_valid.
- m_eof  out  1  last payload byte of frame; qualified by m_valid.
- m_err  out  1  on eof beat: CRC bad, runt, or giant.
- m_len  out  LEN_W  post-SFD byte count incl. FCS, saturating; valid on eof beat.
- drop  out  1  one-cycle pulse when an attempted frame is discarded.

Behaviour:
- Reset (rst=0 sampled):
  - All outputs 0; FSM=IDLE; buffer count=0; CRC=0xFFFFFFFF; len=0.
  - prev_valid is set to 1, so a frame in progress when reset is released is ignored.
- FSM states and transitions:
  - IDLE: rx_valid=1 & prev_valid=0 & data=0x55 -> PREAMBLE, pcnt=1. rx_valid=1 & prev_valid=0 & data!=0x55 -> DROP, pulse drop. rx_valid=1 & prev_valid=1 -> DROP, no drop pulse.
  - PREAMBLE: valid & 0x55 -> pcnt++, saturating at 7. valid & 0xD5 & pcnt>=MIN_PREAMBLE -> DATA, clearing CRC, len and buffer. Any other valid byte -> DROP, pulse drop. rx_valid=0 -> IDLE, pulse drop.
  - DATA: each valid byte updates CRC and len, and is pushed into the 5-deep delay line. rx_valid=0 -> finalise (see end of frame), then IDLE.
  - DROP: ignore bytes; rx_valid=0 -> IDLE.
- Emission and latency:
  - When a byte is pushed while the buffer holds 5 bytes, the oldest byte is registered out with m_valid=1.
  - Continuous input: byte N appears on m_data the cycle after byte N+5 is sampled.
  - m_sof=1 on the first emitted byte of a frame.
- End of frame (first rx_valid=0 sampled in DATA):
  - If the buffer holds 5 bytes, the oldest is emitted next cycle with m_eof=1, m_len=len, and m_err = (crc!=0xDEBB20E3) | len<MIN_FRAME | len>MAX_FRAME. The remaining 4 bytes (FCS) are discarded.
  - If the buffer holds <=4 bytes (no payload), nothing is emitted and drop pulses.
  - A single-payload-byte frame emits one beat with sof=eof=1.
- CRC:
  - IEEE 802.3 reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over all post-SFD bytes including FCS.
  - Good frame leaves residue 0xDEBB20E3. One byte per cycle.
- Length: len counts post-SFD bytes and saturates at 2^LEN_W-1; saturation counts as giant.
- Simultaneous events / gaps: a 1-cycle rx_valid=0 gap between frames is sufficient. The eof beat of frame A may coincide with frame B's first preamble byte being sampled.
- Reset mid-frame: no eof is emitted for the truncated frame.

Decomposition:
- eth_pkg (shared package):
  - Constants: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE.
  - Typedef: rx_state_t enum {IDLE, PREAMBLE, DATA, DROP}.
- Sub-module: eth_crc32_byte, a combinational next-CRC function of (crc_in, byte). It is reused by the future TX FCS inserter.

Test Plan:
- 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 60 beats; sof on beat 1, eof on beat 60; err=0, len=64; first beat 6 cycles after the first payload byte is sampled.
- Same frame with payload byte 10 bit 0 flipped -> 60 beats, eof err=1, len=64.
- Valid frame of 59 payload bytes + FCS -> eof err=1 (runt), len=63. 1515 payload bytes -> err=1 (giant), len=1519.
- 2x0x55, 0xD5 with MIN_PREAMBLE=3 -> no beats, single drop pulse. A 3-byte post-SFD burst -> no beats, drop pulse.
- rst=0 for 2 cycles in the middle of frame payload, released while rx_valid=1 -> no output until rx_valid=0; the following good frame is delivered intact.
- Two good 64-byte frames separated by a 1-cycle gap -> 120 beats; two sof, two eof, both err=0.
